if_layer: RTL
=============

Name: if_layer

Overview:
- Parametrised layer of integrate-and-fire (IF) neurons with a programmable weight memory.
- Each timestep, one input spike vector is accepted. Every neuron accumulates the signed weights of the active inputs. The layer then fires and resets every neuron that reaches threshold.
- Neurons are processed in parallel; inputs are processed one per cycle. This trades latency for adder count.
- Sits between spike encoders (or a previous layer) and the next layer or readout. Replaces the fixed four-input, single-neuron network.

Parameters:
- NUM_INPUTS, 4, presynaptic inputs per neuron (>=1).
- NUM_OUTPUTS, 2, neurons in the layer (>=1).
- WEIGHT_WIDTH, 8, signed two's-complement weight width.
- POT_WIDTH, 16, signed membrane potential width (>= WEIGHT_WIDTH+1).
- THRESHOLD, 10, firing threshold; compare is signed, potential >= THRESHOLD.
- RESET_POTENTIAL, 0, value loaded into a neuron after it fires.
- LEAK, 1, amount subtracted per timestep when CFG_LEAK_EN is defined.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- step_valid  input  1  spike_in holds a timestep to be accepted.
- step_ready  output  1  layer idle; can accept a timestep.
- spike_in  input  NUM_INPUTS  input spike vector, sampled on acceptance.
- spike_out  output  NUM_OUTPUTS  registered fire vector, valid while out_valid is high.
- out_valid  output  1  one-cycle pulse marking a completed timestep.
- busy  output  1  high in ACCUM or FIRE.
- wr_en  input  1  weight write strobe.
- wr_neuron  input  max(1,clog2(NUM_OUTPUTS))  target neuron index.
- wr_input  input  max(1,clog2(NUM_INPUTS))  target input index.
- wr_data  input  WEIGHT_WIDTH  signed weight value.

Behaviour:
- Reset (rst low, asynchronous):
  - FSM goes to IDLE.
  - All potentials go to RESET_POTENTIAL; all weights go to 0.
  - spike_out=0, out_valid=0, busy=0, input index=0, captured spike vector=0.
  - Reset mid-timestep aborts the timestep; no out_valid is produced for it.
- State IDLE:
  - step_ready=1.
  - On step_valid & step_ready, capture spike_in, clear the input index and go to ACCUM.
- State ACCUM:
  - Lasts exactly NUM_INPUTS cycles; index i runs 0..NUM_INPUTS-1, one per cycle.
  - For every neuron n, if captured bit i is 1: pot[n] += w[n][i]. The add saturates to the signed POT_WIDTH range (max 2^(POT_WIDTH-1)-1, min -2^(POT_WIDTH-1)).
  - After i = NUM_INPUTS-1, go to FIRE.
- State FIRE (1 cycle), per neuron:
  - If pot[n] >= THRESHOLD: spike_out[n]=1 and pot[n]=RESET_POTENTIAL.
  - Otherwise: spike_out[n]=0 and pot[n] holds (or leaks, see Optional Feature).
  - out_valid=1 in the following cycle; go to IDLE.
- Latency and throughput:
  - out_valid rises NUM_INPUTS+1 clock edges after the accepting edge.
  - spike_out holds its value until the next FIRE or reset.
  - out_valid lasts exactly one cycle.
  - A new step may be accepted in the same cycle out_valid is high.
  - Maximum throughput: one timestep per NUM_INPUTS+2 cycles.
- Handshake rules:
  - step_valid while busy is not accepted, and spike_in changes are ignored.
  - The source holds step_valid and spike_in until step_ready is seen.
- Weight writes:
  - Accepted only when the FSM is IDLE; w[wr_neuron][wr_input] <= wr_data on the next edge.
  - wr_en while busy is dropped; no queuing.
  - Out-of-range indices are dropped.
  - A write and a step acceptance in the same IDLE cycle: the write lands first, so the accepted timestep uses the new weight.
- Other boundary conditions:
  - spike_in all zero still runs the full ACCUM/FIRE sequence.
  - A neuron sitting at THRESHOLD with no input fires at the next FIRE.
  - Potentials persist across timesteps; they clear only on fire or reset.

Optional Feature:
- Macro: CFG_LEAK_EN.
- Defined: in FIRE, each non-firing neuron with pot[n] > RESET_POTENTIAL becomes max(pot[n]-LEAK, RESET_POTENTIAL). Neurons at or below RESET_POTENTIAL are unchanged. Firing neurons reset as usual.
- Undefined: pure IF; no leak logic or LEAK usage is synthesised.

Test Plan:
- Basic fire: defaults, w[0][*]=3, step spike_in=4'b0111 -> out_valid with spike_out=2'b00, pot0=9. Next step spike_in=4'b0001 -> spike_out[0]=1, pot0 back to 0.
- Latency and handshake: hold step_valid continuously -> step_ready low for 5 cycles after acceptance. out_valid 5 edges after the accepting edge. Next step accepted in the out_valid cycle. Steps repeat every 6 cycles.
- Saturation: POT_WIDTH=8, w[1][*]=-5, repeated spike_in=4'b1111 -> pot1 sequence -20,-40,...,-120, then clamps at -128 with no wrap. Never fires.
- Write gating: wr_en with wr_data=7 issued during ACCUM -> weight unchanged and timestep result unaffected. Same write in IDLE -> used by the next timestep.
- Reset mid-operation: drop rst during ACCUM (i=2) -> outputs 0 immediately. No out_valid. Weights read back 0 (no fire with spike_in=4'b1111). step_ready high after release.
- Leak (CFG_LEAK_EN, LEAK=1): w[0][0]=5, spike_in=4'b0001 once, then zero vectors -> pot0 sequence 4,3,2,1,0,0, no spikes. Same test without the macro -> pot0 stays 5.

Source files
------------

// File: rtl/if_layer_if.sv
// Bundles the timestep handshake, fire outputs and weight-write port of if_layer.
// master = spike source / weight programmer, slave = the neuron layer.
interface if_layer_if #(
    parameter int NUM_INPUTS   = 4,
    parameter int NUM_OUTPUTS  = 2,
    parameter int WEIGHT_WIDTH = 8
);
    localparam int NEURON_IDX_W = (NUM_OUTPUTS > 1) ? $clog2(NUM_OUTPUTS) : 1;
    localparam int INPUT_IDX_W  = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;

    logic                    step_valid;
    logic                    step_ready;
    logic [NUM_INPUTS-1:0]   spike_in;
    logic [NUM_OUTPUTS-1:0]  spike_out;
    logic                    out_valid;
    logic                    busy;
    logic                    wr_en;
    logic [NEURON_IDX_W-1:0] wr_neuron;
    logic [INPUT_IDX_W-1:0]  wr_input;
    logic [WEIGHT_WIDTH-1:0] wr_data;

    modport master (
        output step_valid, spike_in, wr_en, wr_neuron, wr_input, wr_data,
        input  step_ready, spike_out, out_valid, busy
    );

    modport slave (
        input  step_valid, spike_in, wr_en, wr_neuron, wr_input, wr_data,
        output step_ready, spike_out, out_valid, busy
    );
endinterface

// File: rtl/if_layer.sv
// Layer of integrate-and-fire neurons with a programmable weight memory.
// All neurons integrate in parallel; inputs are walked one per cycle, then a
// single FIRE cycle thresholds and resets every neuron.
// Optional macro CFG_LEAK_EN: non-firing neurons above RESET_POTENTIAL leak by
// LEAK per timestep (clamped at RESET_POTENTIAL).
module if_layer #(
    parameter int NUM_INPUTS      = 4,
    parameter int NUM_OUTPUTS     = 2,
    parameter int WEIGHT_WIDTH    = 8,
    parameter int POT_WIDTH       = 16,
    parameter int THRESHOLD       = 10,
    parameter int RESET_POTENTIAL = 0,
    parameter int LEAK            = 1
) (
    input  logic      clk,
    input  logic      rst,
    if_layer_if.slave bus
);
    localparam int IDX_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
    localparam int NIDX_W = (NUM_OUTPUTS > 1) ? $clog2(NUM_OUTPUTS) : 1;

    localparam logic signed [POT_WIDTH-1:0] POT_MAX   = {1'b0, {(POT_WIDTH-1){1'b1}}};
    localparam logic signed [POT_WIDTH-1:0] POT_MIN   = {1'b1, {(POT_WIDTH-1){1'b0}}};
    localparam logic signed [POT_WIDTH-1:0] POT_RESET = POT_WIDTH'(RESET_POTENTIAL);
    localparam logic [IDX_W-1:0]            IDX_LAST  = IDX_W'(NUM_INPUTS - 1);

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_FIRE} state_t;

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [NUM_INPUTS-1:0]   spikes_q, spikes_d;
    logic [NUM_OUTPUTS-1:0]  spike_out_q, spike_out_d;
    logic                    out_valid_q, out_valid_d;
    logic [NUM_OUTPUTS-1:0]  fire_now;
    logic                    wr_ok;

    logic signed [POT_WIDTH-1:0]    pot_q [NUM_OUTPUTS];
    logic signed [POT_WIDTH-1:0]    pot_d [NUM_OUTPUTS];
    logic signed [WEIGHT_WIDTH-1:0] w_q [NUM_OUTPUTS][NUM_INPUTS];
    logic signed [WEIGHT_WIDTH-1:0] w_d [NUM_OUTPUTS][NUM_INPUTS];

    // Add a weight to a potential, clamping to the signed potential range.
    function automatic logic signed [POT_WIDTH-1:0] sat_add(
        input logic signed [POT_WIDTH-1:0]    a,
        input logic signed [WEIGHT_WIDTH-1:0] b
    );
        logic [POT_WIDTH:0] s;
        s = {a[POT_WIDTH-1], a} + {{(POT_WIDTH+1-WEIGHT_WIDTH){b[WEIGHT_WIDTH-1]}}, b};
        if (s[POT_WIDTH] != s[POT_WIDTH-1]) begin
            sat_add = s[POT_WIDTH] ? POT_MIN : POT_MAX;
        end else begin
            sat_add = s[POT_WIDTH-1:0];
        end
    endfunction

    // Weights may only change while no timestep is in flight.
    assign wr_ok = bus.wr_en && (state_q == S_IDLE);

    assign bus.step_ready = (state_q == S_IDLE);
    assign bus.busy       = (state_q != S_IDLE);
    assign bus.spike_out  = spike_out_q;
    assign bus.out_valid  = out_valid_q;

    // Sequencer next-state: capture on accept, walk inputs, single FIRE cycle.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        spikes_d    = spikes_q;
        spike_out_d = spike_out_q;
        out_valid_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.step_valid) begin
                    spikes_d = bus.spike_in;
                    idx_d    = '0;
                    state_d  = S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (idx_q == IDX_LAST) begin
                    idx_d   = '0;
                    state_d = S_FIRE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            S_FIRE: begin
                spike_out_d = fire_now;
                out_valid_d = 1'b1;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Sequencer and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            spikes_q    <= '0;
            spike_out_q <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            spikes_q    <= spikes_d;
            spike_out_q <= spike_out_d;
            out_valid_q <= out_valid_d;
        end
    end

    genvar gi, gj;
    generate
        for (gi = 0; gi < NUM_OUTPUTS; gi++) begin : g_neuron
            assign fire_now[gi] = (pot_q[gi] >= THRESHOLD);

            // Membrane update: integrate the current input in ACCUM, threshold in FIRE.
            always_comb begin
`ifdef CFG_LEAK_EN
                logic signed [POT_WIDTH:0] leak_diff;
                leak_diff = '0;
`endif
                pot_d[gi] = pot_q[gi];
                if (state_q == S_ACCUM) begin
                    if (spikes_q[idx_q]) begin
                        pot_d[gi] = sat_add(pot_q[gi], w_q[gi][idx_q]);
                    end
                end else if (state_q == S_FIRE) begin
                    if (fire_now[gi]) begin
                        pot_d[gi] = POT_RESET;
                    end
`ifdef CFG_LEAK_EN
                    else if (pot_q[gi] > POT_RESET) begin
                        // Widened subtract so a leak near the negative rail cannot wrap.
                        leak_diff = $signed({pot_q[gi][POT_WIDTH-1], pot_q[gi]})
                                    - $signed((POT_WIDTH+1)'(LEAK));
                        pot_d[gi] = (leak_diff > $signed({POT_RESET[POT_WIDTH-1], POT_RESET}))
                                    ? leak_diff[POT_WIDTH-1:0] : POT_RESET;
                    end
`endif
                end
            end

            // Membrane potential register.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    pot_q[gi] <= POT_RESET;
                end else begin
                    pot_q[gi] <= pot_d[gi];
                end
            end

            for (gj = 0; gj < NUM_INPUTS; gj++) begin : g_syn
                // Weight write decode; indices outside the array never match and are dropped.
                always_comb begin
                    w_d[gi][gj] = w_q[gi][gj];
                    if (wr_ok && (bus.wr_neuron == NIDX_W'(gi)) && (bus.wr_input == IDX_W'(gj))) begin
                        w_d[gi][gj] = bus.wr_data;
                    end
                end

                // Weight register.
                always_ff @(posedge clk or negedge rst) begin
                    if (!rst) begin
                        w_q[gi][gj] <= '0;
                    end else begin
                        w_q[gi][gj] <= w_d[gi][gj];
                    end
                end
            end
        end
    endgenerate
endmodule
